// File: rtl/user_mgr_arbiter_pkg.sv
// Shared types and constants for the user-domain manager arbiter.
package user_mgr_arbiter_pkg;

    // Upstream manager slots on the shared user-domain OBI port
    typedef enum logic [0:0] {
        UserMgrCnn = 1'b0,
        UserMgrDma = 1'b1
    } user_mgr_idx_e;

    localparam int unsigned NumUserMgr      = 2;
    localparam int unsigned UserMgrMaxTrans = 4;

    localparam int unsigned ObiAddrWidth = 32;
    localparam int unsigned ObiDataWidth = 32;
    localparam int unsigned ObiIdWidth   = 1;

    typedef struct packed {
        logic [ObiAddrWidth-1:0]   addr;
        logic                      we;
        logic [ObiDataWidth/8-1:0] be;
        logic [ObiDataWidth-1:0]   wdata;
        logic [ObiIdWidth-1:0]     aid;
    } mgr_obi_a_chan_t;

    typedef struct packed {
        mgr_obi_a_chan_t a;
        logic            req;
    } mgr_obi_req_t;

    typedef struct packed {
        logic [ObiDataWidth-1:0] rdata;
        logic [ObiIdWidth-1:0]   rid;
        logic                    err;
    } mgr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        mgr_obi_r_chan_t r;
    } mgr_obi_rsp_t;

    // Width of a manager index; at least one bit even for a single manager
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/user_mgr_id_fifo.sv
// In-order FIFO of manager indices for outstanding OBI transactions.
module user_mgr_id_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_q;
    logic [PtrW-1:0]  rd_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage; contents are only meaningful while occupied
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/user_mgr_arbiter.sv
// Round-robin arbiter sharing the user-domain OBI manager port, with
// in-order response routing and an outstanding-transaction limit.
module user_mgr_arbiter
    import user_mgr_arbiter_pkg::*;
#(
    parameter int unsigned NumMgr      = 2,
    parameter int unsigned NumMaxTrans = 4,
    parameter type         obi_req_t   = mgr_obi_req_t,
    parameter type         obi_rsp_t   = mgr_obi_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t sbr_ports_req_i [NumMgr],
    output obi_rsp_t sbr_ports_rsp_o [NumMgr],
    output obi_req_t mgr_port_req_o,
    input  obi_rsp_t mgr_port_rsp_i,
    output logic     busy_o,
    output logic     rsp_err_o
);

    localparam int unsigned IdxW = idx_width(NumMgr);

    logic [NumMgr-1:0] req_vec;
    logic [IdxW-1:0]   rr_q;
    logic [IdxW-1:0]   sel_q;
    logic              locked_q;
    logic [IdxW-1:0]   winner;
    logic [IdxW-1:0]   cand;
    logic              found;
    logic [IdxW-1:0]   head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fwd_req;
    logic              accept;
    logic              pop;
    logic              rsp_err_q;

    // Gather request bits
    always_comb begin
        req_vec = '0;
        for (int unsigned i = 0; i < NumMgr; i++) begin
            req_vec[i] = sbr_ports_req_i[i].req;
        end
    end

    // First requester at or after the pointer wins; a held lock overrides
    always_comb begin
        winner = rr_q;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned off = 0; off < NumMgr; off++) begin
            cand = IdxW'((32'(rr_q) + off) % NumMgr);
            if (!found && req_vec[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
        if (locked_q) begin
            winner = sel_q;
        end
    end

    // Full uses the registered count, so a same-cycle pop cannot unblock
    assign fwd_req = rst_ni & req_vec[winner] & ~fifo_full;
    assign accept  = fwd_req & mgr_port_rsp_i.gnt;
    assign pop     = mgr_port_rsp_i.rvalid & ~fifo_empty;

    // Hold the selection while a forwarded request waits for its grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            locked_q <= 1'b0;
            sel_q    <= '0;
        end else if (locked_q) begin
            if (accept || !req_vec[sel_q]) begin
                locked_q <= 1'b0;
            end
        end else if (fwd_req && !mgr_port_rsp_i.gnt) begin
            locked_q <= 1'b1;
            sel_q    <= winner;
        end
    end

    // Advance the round-robin pointer past each granted manager
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else if (accept) begin
            rr_q <= IdxW'((32'(winner) + 1) % NumMgr);
        end
    end

    // Sticky flag for responses that arrive with nothing outstanding
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_err_q <= 1'b0;
        end else if (mgr_port_rsp_i.rvalid && fifo_empty) begin
            rsp_err_q <= 1'b1;
        end
    end

    user_mgr_id_fifo #(
        .Depth (NumMaxTrans),
        .Width (IdxW)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .data_i  (winner),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    // Downstream request: winner passed through; all-zero while in reset
    always_comb begin
        mgr_port_req_o = '0;
        if (rst_ni) begin
            mgr_port_req_o     = sbr_ports_req_i[winner];
            mgr_port_req_o.req = fwd_req;
        end
    end

    // Upstream responses: grant to the winner, r-channel to the FIFO head
    always_comb begin
        for (int unsigned i = 0; i < NumMgr; i++) begin
            sbr_ports_rsp_o[i] = '0;
            if (IdxW'(i) == winner) begin
                sbr_ports_rsp_o[i].gnt = accept;
            end
            if (pop && (IdxW'(i) == head)) begin
                sbr_ports_rsp_o[i].r      = mgr_port_rsp_i.r;
                sbr_ports_rsp_o[i].rvalid = 1'b1;
            end
        end
    end

    assign busy_o    = ~fifo_empty | fwd_req;
    assign rsp_err_o = rsp_err_q;

endmodule

// File: doc/user_mgr_arbiter.md
Name: user_mgr_arbiter

Overview:
- Round-robin arbiter that shares the single user-domain OBI manager port towards Croc between several user managers: the CNN accelerator today, and a DMA/streamer later.
- Replaces the direct CNN-to-port assignment in user_domain.
- Tracks outstanding transactions in an in-order ID FIFO so that each response is returned to the manager that issued the request.
- Enforces OBI A-channel stability: the selected request is never switched while it is ungranted.

Parameters:
- NumMgr, 2, number of upstream user managers (index 0 = CNN, 1 = DMA); must be >= 1.
- NumMaxTrans, 4, maximum outstanding transactions on the downstream port; must be >= 1.
- obi_req_t, mgr_obi_req_t, OBI request struct type.
- obi_rsp_t, mgr_obi_rsp_t, OBI response struct type.

Ports:
- clk_i  input  1  system clock; single clock domain.
- rst_ni  input  1  asynchronous active-low reset.
- sbr_ports_req_i  input  NumMgr x obi_req_t  requests from the user managers.
- sbr_ports_rsp_o  output  NumMgr x obi_rsp_t  responses to the user managers.
- mgr_port_req_o  output  obi_req_t  request towards Croc (drives user_mgr_obi_req_o).
- mgr_port_rsp_i  input  obi_rsp_t  response from Croc.
- busy_o  output  1  high while the FIFO is non-empty or mgr_port_req_o.req is high.
- rsp_err_o  output  1  sticky flag: an rvalid arrived while no transaction was outstanding.

Behaviour:
- Reset values:
  - mgr_port_req_o is all zero.
  - All sbr_ports_rsp_o gnt, rvalid and rdata are 0.
  - RR pointer = 0, lock = 0, FIFO empty.
  - busy_o = 0, rsp_err_o = 0.
- Arbitration (combinational, zero latency):
  - The winner is the first requesting index at or after the RR pointer, modulo NumMgr.
  - The winner's a-fields are passed unchanged to mgr_port_req_o, and req_o = winner req.
  - mgr_port_rsp_i.gnt is routed only to the winner; all other gnt are 0.
- Lock:
  - Condition: req_o = 1, gnt = 0 and FIFO not full.
  - Action: register locked_q = 1 and sel_q = winner.
  - While locked, selection is forced to sel_q regardless of the RR pointer or new requesters.
  - The lock clears on the cycle gnt = 1.
- RR pointer update: on each accepted grant (req & gnt), pointer <= (winner + 1) mod NumMgr. No update otherwise.
- FIFO push: on each accepted grant, push the winner index, width max(1, clog2(NumMgr)).
- Full FIFO:
  - When the FIFO is full, req_o = 0 and all upstream gnt = 0.
  - A same-cycle pop does NOT unblock; the new request is forwarded the following cycle.
  - A pending locked request stays locked and keeps its selection.
- Response routing:
  - When mgr_port_rsp_i.rvalid = 1 and the FIFO is non-empty, copy the r-fields (rdata, err, rid) to sbr_ports_rsp_o[head], assert that port's rvalid, and pop.
  - The rvalid of all other ports is 0.
  - A response is delivered in the same cycle it arrives (zero added latency).
- Spurious response: rvalid = 1 with an empty FIFO is dropped, no port sees rvalid, and rsp_err_o is set. rsp_err_o clears only on reset.
- Simultaneous push and pop (not full): both are performed, and the count is unchanged.
- Ordering: the downstream port is assumed to return responses in order; no rid-based reordering is done.
- NumMgr = 1: the module degenerates to a pass-through plus the transaction limiter; the pointer stays 0.
- Reset mid-transaction: all state clears immediately and late responses count as spurious. The system resets Croc together with this block.

Decomposition:
- user_pkg additions:
  - typedef enum user_mgr_idx_e {UserMgrCnn = 0, UserMgrDma = 1}.
  - localparam NumUserMgr = 2.
  - localparam UserMgrMaxTrans = 4.
- Sub-module user_mgr_id_fifo: depth NumMaxTrans, width param, push/pop/full/empty/head, async active-low reset. It is self-contained and tested standalone.
- user_domain: replace the direct assignments with this block and pack cnn_mgr_obi_req/rsp into index UserMgrCnn.

Test Plan:
- Single CNN read, addr 0x1000_0000: gnt in cycle 0, rvalid with rdata 0xDEADBEEF two cycles later → only port 0 sees gnt and rvalid, rdata = 0xDEADBEEF, busy_o drops after the response.
- Both managers request continuously, gnt always 1 → grants alternate 0,1,0,1 over 8 cycles, and responses return to the matching port in issue order.
- Port 1 requests with gnt held low for 3 cycles while port 0 raises req in cycle 1 → selection stays on port 1, mgr_port_req_o addr/wdata are stable all 4 cycles, and port 0 is granted next.
- Issue 4 grants with no responses (NumMaxTrans = 4), then a 5th request → req_o = 0 while full; return 1 response → the 5th request is forwarded the following cycle, not the pop cycle.
- rvalid pulse after reset with no outstanding transactions → no port rvalid, rsp_err_o = 1 and stays 1 until rst_ni is asserted.
- Assert rst_ni low with 2 transactions outstanding and port 1 locked → all outputs are zero asynchronously; after release the pointer = 0 and the FIFO is empty.
